// File: rtl/traffic_phase_ctrl_if.sv
// Lamp / countdown bundle between the phase controller and its surroundings.
// The controller side (master) drives lamps, countdown and splitter enable;
// the environment side (slave) drives the night request.
interface traffic_phase_ctrl_if;
  logic       night;
  logic [2:0] main_rgy;
  logic [2:0] side_rgy;
  logic [4:0] count;
  logic       split_en;

  modport master (
    input  night,
    output main_rgy,
    output side_rgy,
    output count,
    output split_en
  );

  modport slave (
    output night,
    input  main_rgy,
    input  side_rgy,
    input  count,
    input  split_en
  );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Two-road traffic-light phase controller.
// A prescaler produces a one-cycle tick every TICK_DIV clocks. On each tick the
// ring MG->MY->AR1->SG->SY->AR2 counts down N..1 per phase, or switches to /
// from flashing-yellow night mode. Lamps are decoded from the next state and
// registered, so they change on the same edge as the state.
module traffic_phase_ctrl #(
  parameter int TICK_DIV = 50_000_000,
  parameter int G_MAIN   = 25,
  parameter int G_SIDE   = 15,
  parameter int Y_TIME   = 3,
  parameter int ALL_RED  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  traffic_phase_ctrl_if.master bus
);

  localparam int              PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRE_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_MG,
    S_MY,
    S_AR1,
    S_SG,
    S_SY,
    S_AR2,
    S_FLASH
  } state_t;

  logic [PW-1:0] r_pre;
  state_t        r_state;
  logic [4:0]    r_count;
  logic          r_blink;
  logic [2:0]    r_main;
  logic [2:0]    r_side;
  logic          r_split_en;

  logic          w_tick;
  state_t        w_nxt_state;
  logic [4:0]    w_nxt_count;
  logic          w_nxt_blink;
  logic [5:0]    w_lamps;

  // Successor of a ring state; FLASH is not part of the ring.
  function automatic state_t f_next_ring(input state_t s);
    case (s)
      S_MG:    f_next_ring = S_MY;
      S_MY:    f_next_ring = S_AR1;
      S_AR1:   f_next_ring = S_SG;
      S_SG:    f_next_ring = S_SY;
      S_SY:    f_next_ring = S_AR2;
      default: f_next_ring = S_MG;
    endcase
  endfunction

  // Duration loaded into the countdown when a ring state is entered.
  function automatic logic [4:0] f_dur(input state_t s);
    case (s)
      S_MG:          f_dur = 5'(G_MAIN);
      S_MY, S_SY:    f_dur = 5'(Y_TIME);
      S_SG:          f_dur = 5'(G_SIDE);
      default:       f_dur = 5'(ALL_RED);
    endcase
  endfunction

  // Lamp decode {main_rgy, side_rgy}, each {red, yellow, green}.
  function automatic logic [5:0] f_lamps(input state_t s, input logic blink);
    case (s)
      S_MG:    f_lamps = {3'b001, 3'b100};
      S_MY:    f_lamps = {3'b010, 3'b100};
      S_SG:    f_lamps = {3'b100, 3'b001};
      S_SY:    f_lamps = {3'b100, 3'b010};
      S_FLASH: f_lamps = blink ? {3'b010, 3'b010} : 6'b000000;
      default: f_lamps = {3'b100, 3'b100};
    endcase
  endfunction

  assign w_tick = (r_pre == PRE_MAX);

  // Prescaler: 0..TICK_DIV-1, wrapping on the tick cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  // Next-state rules applied on a tick: night first, then phase end, then decrement.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_count = r_count;
    w_nxt_blink = r_blink;
    if (w_tick) begin
      if (r_state == S_FLASH) begin
        if (bus.night) begin
          w_nxt_blink = ~r_blink;
        end else begin
          w_nxt_state = S_AR2;
          w_nxt_count = 5'(ALL_RED);
        end
      end else if (bus.night) begin
        w_nxt_state = S_FLASH;
        w_nxt_count = '0;
        w_nxt_blink = 1'b1;
      end else if (r_count == 5'd1) begin
        w_nxt_state = f_next_ring(r_state);
        w_nxt_count = f_dur(f_next_ring(r_state));
      end else begin
        w_nxt_count = r_count - 5'd1;
      end
    end
  end

  assign w_lamps = f_lamps(w_nxt_state, w_nxt_blink);

  // Phase FSM with lamps and splitter enable registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_AR2;
      r_count    <= 5'(ALL_RED);
      r_blink    <= 1'b0;
      r_main     <= 3'b100;
      r_side     <= 3'b100;
      r_split_en <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_count    <= w_nxt_count;
      r_blink    <= w_nxt_blink;
      r_main     <= w_lamps[5:3];
      r_side     <= w_lamps[2:0];
      r_split_en <= (w_nxt_state != S_FLASH);
    end
  end

  assign bus.main_rgy = r_main;
  assign bus.side_rgy = r_side;
  assign bus.count    = r_count;
  assign bus.split_en = r_split_en;

endmodule
